// File: rtl/fetch_pkg.sv
// Shared widths, constants, state encoding and queue entry type for the
// instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc}; flush wins over a same-cycle push or pop.
// Storage resets to zero so the head reads as zero straight out of reset.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests to a
// req/gnt in-order memory, prefetch queue to ID, redirect with stale drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               instr_ready_i
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] inflight, drop, count;
  logic          credit_ok, fire, rsp_live, rsp_drop, pop;
  logic [CW-1:0] inflight_after_rsp;
  fetch_entry_t  push_data, head;

  // Queue slots are reserved at request time, so a push never meets a full queue.
  assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);

  assign imem_req_o  = (state == ST_RUN) & start_i & ~redirect_i & credit_ok;
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o & imem_gnt_i;

  assign rsp_live = imem_rvalid_i & ~redirect_i & (drop == '0);
  assign rsp_drop = imem_rvalid_i & ~redirect_i & (drop != '0);

  assign instr_valid_o = (count != '0) & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;

  assign push_data          = '{instr: imem_rdata_i, pc: resp_pc};
  assign inflight_after_rsp = inflight - CW'(imem_rvalid_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      if (state == ST_IDLE && start_i) state <= ST_RUN;
      if (redirect_i) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= align_pc(redirect_pc_i);
        resp_pc  <= align_pc(redirect_pc_i);
        inflight <= inflight_after_rsp;
        drop     <= inflight_after_rsp;
      end else begin
        if (fire)     fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (rsp_live) resp_pc  <= resp_pc + XLEN'(PC_STEP);
        if (rsp_drop) drop     <= drop - CW'(1);
        inflight <= inflight + CW'(fire) - CW'(imem_rvalid_i);
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (redirect_i),
    .push      (rsp_live),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign instr_o = head.instr;
  assign pc_o    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory stub, a
// queue-based reference model checked every cycle, plus literal spot checks.
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o, pc_o;
  logic        instr_ready_i = 1'b0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  int npass = 0, nchk = 0, cyc = 0, lat = 1;
  bit gnt_en = 1'b1;
  // reference model
  bit m_run;
  logic [31:0] m_fpc, m_rpc;
  int m_infl, m_drop;
  ent_t  mq[$];
  pend_t mp[$];
  // observation logs
  logic [31:0] pops[$], grants[$];
  bit last_valid, last_rvalid;
  int first_grant_cyc, first_valid_cyc;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_run = 0; m_fpc = RST_PC; m_rpc = RST_PC; m_infl = 0; m_drop = 0;
    mq.delete(); mp.delete(); pops.delete(); grants.delete();
    first_grant_cyc = -1; first_valid_cyc = -1;
  endtask

  // One clock cycle: memory drives rvalid, outputs are compared against the
  // model, then model and memory advance to the next cycle.
  task automatic step();
    bit rv, m_req, m_val;
    logic [31:0] rd;
    int sz;
    rv = (mp.size() != 0) && (mp[0].due <= cyc);
    rd = rv ? rdata_of(mp[0].addr) : NOP_INSTR;
    imem_rvalid_i = rv; imem_rdata_i = rd; imem_gnt_i = gnt_en;
    #1;
    sz    = mq.size();
    m_req = m_run && start_i && !redirect_i && (m_infl + sz < DEPTH);
    m_val = (sz != 0) && !redirect_i;
    chk("req", imem_req_o, m_req);
    chk("addr", imem_addr_o, m_fpc);
    chk("valid", instr_valid_o, m_val);
    if (m_val) begin
      chk("instr", instr_o, mq[0].instr);
      chk("pc", pc_o, mq[0].pc);
    end
    chk("count", dut.u_queue.count, sz);
    chk("inflight", dut.inflight, m_infl);
    chk("drop", dut.drop, m_drop);
    if (rv && m_infl == 0) chk("rvalid_with_no_inflight", 1, 0);
    last_valid = instr_valid_o; last_rvalid = rv;
    if (instr_valid_o && instr_ready_i) pops.push_back(pc_o);
    if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (rv) mp.pop_front();
    if (imem_req_o && gnt_en) begin
      grants.push_back(imem_addr_o);
      mp.push_back('{imem_addr_o, cyc + lat});
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
    if (redirect_i) begin
      mq.delete();
      m_fpc = {redirect_pc_i[31:2], 2'b00}; m_rpc = m_fpc;
      m_infl -= rv; m_drop = m_infl;
    end else begin
      if (m_req && gnt_en) begin m_fpc += 4; m_infl++; end
      if (m_val && instr_ready_i) mq.pop_front();
      if (rv) begin
        m_infl--;
        if (m_drop > 0) m_drop--;
        else begin mq.push_back('{rd, m_rpc}); m_rpc += 4; end
      end
    end
    if (!m_run && start_i) m_run = 1;
    @(posedge clk_i); #1; cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 0; redirect_i = 0; instr_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; gnt_en = 1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    rst_i = 1'b1; cyc = 0;
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    logic [31:0] lastpc;
    int n;

    // 1: streaming with single-cycle memory
    do_reset();
    lat = 1; start_i = 1; instr_ready_i = 1;
    repeat (12) step();
    chk("t1_latency", first_valid_cyc - first_grant_cyc, 2);
    chk("t1_npops", pops.size() >= 8, 1);
    for (int i = 0; i < 8; i++) chk("t1_pc_seq", at(pops, i), i * 4);

    // 2: ID stall fills the queue and throttles requests
    lastpc = pops[$];
    instr_ready_i = 0;
    repeat (10) step();
    chk("t2_full", dut.u_queue.count, DEPTH);
    chk("t2_req_off", imem_req_o, 0);
    pops.delete();
    instr_ready_i = 1;
    repeat (8) step();
    for (int i = 0; i < 8; i++) chk("t2_resume_seq", at(pops, i), lastpc + 4 + i * 4);

    // 3: redirect with three slow requests outstanding
    do_reset();
    lat = 5; start_i = 1; instr_ready_i = 1;
    repeat (4) step();
    chk("t3_inflight", dut.inflight, 3);
    pops.delete(); grants.delete();
    redirect_i = 1; redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 0;
    chk("t3_drop", dut.drop, 3);
    repeat (10) step();
    chk("t3_first_grant", at(grants, 0), 32'h0000_0100);
    chk("t3_first_pop", at(pops, 0), 32'h0000_0100);

    // 4: redirect coinciding with rvalid and a would-be pop
    do_reset();
    lat = 2; start_i = 1; instr_ready_i = 1;
    n = 0;
    while (!((mp.size() != 0) && (mp[0].due <= cyc) && (mq.size() != 0)) && n < 30) begin
      step(); n++;
    end
    chk("t4_setup_reached", n < 30, 1);
    pops.delete(); grants.delete();
    redirect_i = 1; redirect_pc_i = 32'h0000_0200;
    step();
    redirect_i = 0;
    chk("t4_rvalid_seen", last_rvalid, 1);
    chk("t4_valid_low", last_valid, 0);
    chk("t4_no_pop", pops.size(), 0);
    chk("t4_count", dut.u_queue.count, 0);
    chk("t4_inflight", dut.inflight, 1);
    chk("t4_drop", dut.drop, 1);
    repeat (8) step();
    chk("t4_first_pop", at(pops, 0), 32'h0000_0200);

    // 5: PC wrap at the top of the address space
    do_reset();
    lat = 1; start_i = 1; instr_ready_i = 1;
    repeat (3) step();
    pops.delete(); grants.delete();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFB;
    step();
    redirect_i = 0;
    repeat (6) step();
    chk("t5_grant0", at(grants, 0), 32'hFFFF_FFF8);
    chk("t5_grant1", at(grants, 1), 32'hFFFF_FFFC);
    chk("t5_grant2", at(grants, 2), 32'h0000_0000);
    chk("t5_pop0", at(pops, 0), 32'hFFFF_FFF8);
    chk("t5_pop2", at(pops, 2), 32'h0000_0000);

    // 6: asynchronous reset mid-operation
    do_reset();
    lat = 3; start_i = 1; instr_ready_i = 0;
    n = 0;
    while (!(m_infl == 2 && mq.size() == 2) && n < 20) begin step(); n++; end
    chk("t6_setup_reached", n < 20, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_async_req", imem_req_o, 0);
    chk("t6_async_addr", imem_addr_o, RST_PC);
    chk("t6_async_valid", instr_valid_o, 0);
    chk("t6_async_instr", instr_o, 0);
    chk("t6_async_pc", pc_o, 0);
    do_reset();
    lat = 1; start_i = 1; instr_ready_i = 1;
    repeat (5) step();
    chk("t6_first_grant", at(grants, 0), RST_PC);
    chk("t6_first_pop", at(pops, 0), RST_PC);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, nchk);
    $fatal(1, "watchdog expired");
  end
endmodule
